// File: rtl/work_calendar_feeder.sv
// rtl/work_calendar_feeder.sv - day/weekday calendar with tagged lookahead request FIFO (optional month counter: WCF_MONTH_CNT_EN)
module work_calendar_feeder #(
    parameter int DAYS_PER_MONTH = 30,
    parameter int DATE_W         = 5,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [DATE_W-1:0] load_date,
    input  logic [2:0]        load_week,
    output logic              load_err,
    output logic [DATE_W-1:0] cur_date,
    output logic [2:0]        cur_week,
    input  logic              req_valid,
    input  logic [2:0]        req_n,
    output logic              req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATE_W-1:0] out_tod,
    output logic [2:0]        out_week,
    output logic [2:0]        out_n
`ifdef WCF_MONTH_CNT_EN
    ,
    output logic [3:0]        cur_month,
    output logic [3:0]        out_month
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic              load_ok;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [DATE_W-1:0] mem_date [FIFO_DEPTH];
    logic [2:0]        mem_week [FIFO_DEPTH];
    logic [2:0]        mem_n    [FIFO_DEPTH];
`ifdef WCF_MONTH_CNT_EN
    logic [3:0]        mem_month [FIFO_DEPTH];
`endif

    assign load_ok   = (load_date != '0) && (load_date <= DATE_W'(DAYS_PER_MONTH)) && (load_week != 3'd0);
    assign out_valid = (count != '0);
    assign req_ready = (count < CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = out_valid && out_ready;

    // Calendar state: a load (legal or not) masks any same-cycle day_tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_date  <= DATE_W'(1);
            cur_week  <= 3'd1;
            load_err  <= 1'b0;
`ifdef WCF_MONTH_CNT_EN
            cur_month <= 4'd1;
`endif
        end else begin
            load_err <= load && !load_ok;
            if (load) begin
                if (load_ok) begin
                    cur_date  <= load_date;
                    cur_week  <= load_week;
`ifdef WCF_MONTH_CNT_EN
                    cur_month <= 4'd1;
`endif
                end
            end else if (day_tick) begin
                cur_date <= (cur_date == DATE_W'(DAYS_PER_MONTH)) ? DATE_W'(1) : cur_date + DATE_W'(1);
                cur_week <= (cur_week == 3'd7) ? 3'd1 : cur_week + 3'd1;
`ifdef WCF_MONTH_CNT_EN
                if (cur_date == DATE_W'(DAYS_PER_MONTH))
                    cur_month <= (cur_month == 4'd12) ? 4'd1 : cur_month + 4'd1;
`endif
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: snapshot of the calendar as registered in the accept cycle
    always_ff @(posedge clk) begin
        if (push) begin
            mem_date[wr_ptr]  <= cur_date;
            mem_week[wr_ptr]  <= cur_week;
            mem_n[wr_ptr]     <= req_n;
`ifdef WCF_MONTH_CNT_EN
            mem_month[wr_ptr] <= cur_month;
`endif
        end
    end

    // Head presentation: zeros whenever the FIFO is empty
    always_comb begin
        out_tod   = '0;
        out_week  = '0;
        out_n     = '0;
`ifdef WCF_MONTH_CNT_EN
        out_month = '0;
`endif
        if (out_valid) begin
            out_tod   = mem_date[rd_ptr];
            out_week  = mem_week[rd_ptr];
            out_n     = mem_n[rd_ptr];
`ifdef WCF_MONTH_CNT_EN
            out_month = mem_month[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_work_calendar_feeder.sv
// tb/tb_work_calendar_feeder.sv - directed self-checking bench for work_calendar_feeder
module tb_work_calendar_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       day_tick, load, load_err;
    logic [4:0] load_date, cur_date, out_tod;
    logic [2:0] load_week, cur_week, req_n, out_week, out_n;
    logic       req_valid, req_ready, out_valid, out_ready;
`ifdef WCF_MONTH_CNT_EN
    logic [3:0] cur_month, out_month;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    work_calendar_feeder dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_date(load_date), .load_week(load_week), .load_err(load_err),
        .cur_date(cur_date), .cur_week(cur_week),
        .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tod(out_tod), .out_week(out_week), .out_n(out_n)
`ifdef WCF_MONTH_CNT_EN
        , .cur_month(cur_month), .out_month(out_month)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; day_tick = 0; load = 0; load_date = 0; load_week = 0;
        req_valid = 0; req_n = 0; out_ready = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({cur_date, cur_week} !== {5'd1, 3'd1}) begin
            n_fail++; $display("FAIL reset_cal: got %0d/%0d expected 1/1", cur_date, cur_week);
        end
        n_checks++;
        if ({out_valid, req_ready, load_err} !== 3'b010) begin
            n_fail++; $display("FAIL reset_flags: got v=%b r=%b e=%b expected v=0 r=1 e=0", out_valid, req_ready, load_err);
        end
        n_checks++;
        if ({out_tod, out_week, out_n} !== 11'd0) begin
            n_fail++; $display("FAIL reset_head: got %0d/%0d/%0d expected 0/0/0", out_tod, out_week, out_n);
        end
`ifdef WCF_MONTH_CNT_EN
        n_checks++;
        if (cur_month !== 4'd1) begin
            n_fail++; $display("FAIL reset_month: got %0d expected 1", cur_month);
        end
`endif
    endtask

    task automatic test_day_ticks();
        for (int k = 1; k <= 30; k++) begin
            day_tick = 1'b1;
            step();
            n_checks++;
            if ({cur_date, cur_week, load_err} !== {5'((k % 30) + 1), 3'((k % 7) + 1), 1'b0}) begin
                n_fail++;
                $display("FAIL tick_%0d: got %0d/%0d err=%b expected %0d/%0d err=0",
                         k, cur_date, cur_week, load_err, (k % 30) + 1, (k % 7) + 1);
            end
        end
        day_tick = 1'b0;
`ifdef WCF_MONTH_CNT_EN
        n_checks++;
        if (cur_month !== 4'd2) begin
            n_fail++; $display("FAIL month_wrap: got %0d expected 2", cur_month);
        end
`endif
    endtask

    task automatic test_load();
        logic [4:0] bad_date [3];
        logic [2:0] bad_week [3];
        bad_date[0] = 5'd0;  bad_week[0] = 3'd3;
        bad_date[1] = 5'd31; bad_week[1] = 3'd4;
        bad_date[2] = 5'd10; bad_week[2] = 3'd0;
        load = 1; load_date = 5'd28; load_week = 3'd6; day_tick = 1;
        step();
        load = 0; day_tick = 0;
        n_checks++;
        if ({cur_date, cur_week, load_err} !== {5'd28, 3'd6, 1'b0}) begin
            n_fail++; $display("FAIL load_wins: got %0d/%0d err=%b expected 28/6 err=0", cur_date, cur_week, load_err);
        end
`ifdef WCF_MONTH_CNT_EN
        n_checks++;
        if (cur_month !== 4'd1) begin
            n_fail++; $display("FAIL load_month: got %0d expected 1", cur_month);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            load = 1; load_date = bad_date[i]; load_week = bad_week[i]; day_tick = 1;
            step();
            load = 0; day_tick = 0;
            n_checks++;
            if ({cur_date, cur_week, load_err} !== {5'd28, 3'd6, 1'b1}) begin
                n_fail++; $display("FAIL bad_load_%0d: got %0d/%0d err=%b expected 28/6 err=1", i, cur_date, cur_week, load_err);
            end
            step();
            n_checks++;
            if ({cur_date, cur_week, load_err} !== {5'd28, 3'd6, 1'b0}) begin
                n_fail++; $display("FAIL bad_load_clr_%0d: got %0d/%0d err=%b expected 28/6 err=0", i, cur_date, cur_week, load_err);
            end
        end
    endtask

    task automatic test_accept_tick();
        load = 1; load_date = 5'd5; load_week = 3'd2;
        step();
        load = 0;
        req_valid = 1; req_n = 3'd3; day_tick = 1;
        step();
        req_valid = 0; day_tick = 0;
        n_checks++;
        if ({out_valid, out_tod, out_week, out_n} !== {1'b1, 5'd5, 3'd2, 3'd3}) begin
            n_fail++; $display("FAIL snapshot_head: got v=%b %0d/%0d n=%0d expected v=1 5/2 n=3", out_valid, out_tod, out_week, out_n);
        end
        n_checks++;
        if ({cur_date, cur_week} !== {5'd6, 3'd3}) begin
            n_fail++; $display("FAIL snapshot_cur: got %0d/%0d expected 6/3", cur_date, cur_week);
        end
`ifdef WCF_MONTH_CNT_EN
        n_checks++;
        if (out_month !== 4'd1) begin
            n_fail++; $display("FAIL snapshot_month: got %0d expected 1", out_month);
        end
`endif
        out_ready = 1;
        step();
        out_ready = 0;
        n_checks++;
        if ({out_valid, out_tod, out_week, out_n} !== 12'd0) begin
            n_fail++; $display("FAIL empty_head: got v=%b %0d/%0d n=%0d expected all 0", out_valid, out_tod, out_week, out_n);
        end
    endtask

    task automatic test_full();
        out_ready = 0; req_valid = 1; req_n = 3'd1;
        step();
        req_n = 3'd2;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_second_ready: got %b expected 1", req_ready);
        end
        step();
        req_n = 3'd3;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_third_ready: got %b expected 0", req_ready);
        end
        step();
        n_checks++;
        if ({out_valid, out_tod, out_week, out_n} !== {1'b1, 5'd6, 3'd3, 3'd1}) begin
            n_fail++; $display("FAIL full_head_stable: got v=%b %0d/%0d n=%0d expected v=1 6/3 n=1", out_valid, out_tod, out_week, out_n);
        end
        out_ready = 1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_pop_ready: got %b expected 0", req_ready);
        end
        step();
        req_valid = 0;
        n_checks++;
        if ({req_ready, out_valid, out_n} !== {1'b1, 1'b1, 3'd2}) begin
            n_fail++; $display("FAIL first_pop: got r=%b v=%b n=%0d expected r=1 v=1 n=2", req_ready, out_valid, out_n);
        end
        step();
        out_ready = 0;
        n_checks++;
        if ({out_valid, out_n} !== 4'd0) begin
            n_fail++; $display("FAIL second_pop: got v=%b n=%0d expected v=0 n=0", out_valid, out_n);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1; req_n = 3'd0; out_ready = 0;
        step();
        out_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            req_n = 3'(i);
            n_checks++;
            if ({out_valid, req_ready, out_n} !== {1'b1, 1'b1, 3'(i - 1)}) begin
                n_fail++; $display("FAIL stream_%0d: got v=%b r=%b n=%0d expected v=1 r=1 n=%0d", i, out_valid, req_ready, out_n, i - 1);
            end
            step();
        end
        req_valid = 0;
        n_checks++;
        if ({out_valid, out_n} !== {1'b1, 3'd5}) begin
            n_fail++; $display("FAIL stream_last: got v=%b n=%0d expected v=1 n=5", out_valid, out_n);
        end
        step();
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_n = 3'd4; out_ready = 0; day_tick = 1;
        step(); step();
        req_valid = 0; day_tick = 0;
        n_checks++;
        if ({out_valid, req_ready, cur_date} !== {1'b1, 1'b0, 5'd8}) begin
            n_fail++; $display("FAIL pre_reset: got v=%b r=%b date=%0d expected v=1 r=0 date=8", out_valid, req_ready, cur_date);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, req_ready, cur_date, cur_week} !== {1'b0, 1'b1, 5'd1, 3'd1}) begin
            n_fail++; $display("FAIL async_reset: got v=%b r=%b %0d/%0d expected v=0 r=1 1/1", out_valid, req_ready, cur_date, cur_week);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({out_valid, req_ready, cur_date, cur_week, out_n} !== {1'b0, 1'b1, 5'd1, 3'd1, 3'd0}) begin
            n_fail++; $display("FAIL post_reset: got v=%b r=%b %0d/%0d n=%0d expected v=0 r=1 1/1 n=0", out_valid, req_ready, cur_date, cur_week, out_n);
        end
    endtask

    initial begin
        test_reset();
        test_day_ticks();
        test_load();
        test_accept_tick();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
